// File: rtl/led_ctrl.sv
// Memory-mapped LED controller: static pattern, per-channel blink, programmable
// blink half-period and global enable. Defining LED_PWM_EN adds a global PWM brightness stage.
module led_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned PRESC_W = 24
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             WE,
    input  logic [1:0]       Addr,
    input  logic [3:0]       BE,
    input  logic [31:0]      DIn,
    output logic [31:0]      DOut,
    output logic [WIDTH-1:0] LEDLight
);

    typedef enum logic [1:0] {
        ADDR_LIGHT  = 2'd0,
        ADDR_BLINK  = 2'd1,
        ADDR_PERIOD = 2'd2,
        ADDR_CTRL   = 2'd3
    } reg_addr_e;

    // Replace only the bytes whose enable is set; the rest keep the current contents.
    function automatic logic [31:0] byte_merge(input logic [31:0] cur_i,
                                               input logic [31:0] wr_i,
                                               input logic [3:0]  be_i);
        logic [31:0] res;
        res = cur_i;
        for (int k = 0; k < 4; k++) begin
            if (be_i[k]) res[8*k +: 8] = wr_i[8*k +: 8];
        end
        return res;
    endfunction

    reg_addr_e addr;
    logic wr_light, wr_blink, wr_period, wr_ctrl;

    logic [WIDTH-1:0]   light_q, light_d;
    logic [WIDTH-1:0]   blink_q, blink_d;
    logic [PRESC_W-1:0] period_q, period_d;
    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic               en_q, en_d;
    logic               phase_q, phase_d;
    logic [WIDTH-1:0]   led_q, led_d;
    logic [7:0]         duty_rd;
    logic               pwm_on;

    assign addr      = reg_addr_e'(Addr);
    assign wr_light  = WE && (addr == ADDR_LIGHT);
    assign wr_blink  = WE && (addr == ADDR_BLINK);
    assign wr_period = WE && (addr == ADDR_PERIOD);
    assign wr_ctrl   = WE && (addr == ADDR_CTRL);

    // Register file next-state; bits beyond the implemented width are dropped by the casts.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        light_d  = light_q;
        blink_d  = blink_q;
        period_d = period_q;
        en_d     = en_q;
        if (wr_light)  light_d  = WIDTH'(byte_merge(32'(light_q), DIn, BE));
        if (wr_blink)  blink_d  = WIDTH'(byte_merge(32'(blink_q), DIn, BE));
        if (wr_period) period_d = PRESC_W'(byte_merge(32'(period_q), DIn, BE));
        if (wr_ctrl && BE[0]) en_d = DIn[0];
    end

    // Blink prescaler: a zero period pins the phase high so blinking channels stay on.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (wr_period) begin
            cnt_d = '0;
        end else if (cnt_q == period_q - PRESC_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + PRESC_W'(1);
        end
    end

`ifdef LED_PWM_EN
    logic [7:0] duty_q, duty_d;
    logic [7:0] pwm_cnt_q;

    always_comb begin
        duty_d = duty_q;
        if (wr_ctrl && BE[1]) duty_d = DIn[15:8];
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            duty_q    <= 8'h00;
            pwm_cnt_q <= 8'h00;
        end else begin
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
        end
    end

    assign duty_rd = duty_q;
    assign pwm_on  = (duty_q == 8'hFF) || (pwm_cnt_q < duty_q);
`else
    assign duty_rd = 8'h00;
    assign pwm_on  = 1'b1;
`endif

    // Pins are active-low, so the lit mask is inverted before it is registered.
    assign led_d = ~({WIDTH{en_q & pwm_on}} & light_q & (~blink_q | {WIDTH{phase_q}}));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            light_q  <= '0;
            blink_q  <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            phase_q  <= 1'b0;
            led_q    <= '1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            light_q  <= light_d;
            blink_q  <= blink_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            phase_q  <= phase_d;
            led_q    <= led_d;
        end
    end

    assign LEDLight = led_q;

    always_comb begin
        DOut = 32'h0;
        case (addr)
            ADDR_LIGHT:  DOut = 32'(light_q);
            ADDR_BLINK:  DOut = 32'(blink_q);
            ADDR_PERIOD: DOut = 32'(period_q);
            ADDR_CTRL:   DOut = {15'h0, phase_q, duty_rd, 7'h0, en_q};
            default:     DOut = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_led_ctrl.sv
// Self-checking bench for led_ctrl: directed scenarios plus random register traffic,
// checked every cycle against a time-based behavioural model of the controller.
module tb_led_ctrl;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned PRESC_W = 24;
    localparam logic [31:0] PMASK   = (32'h1 << PRESC_W) - 32'h1;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        WE = 1'b0;
    logic [1:0]  Addr = 2'd0;
    logic [3:0]  BE = 4'h0;
    logic [31:0] DIn = 32'h0;
    logic [31:0] DOut;
    logic [WIDTH-1:0] LEDLight;

    int checks = 0;
    int errors = 0;

    led_ctrl #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .Clk(Clk), .Reset(Reset), .WE(WE), .Addr(Addr), .BE(BE),
        .DIn(DIn), .DOut(DOut), .LEDLight(LEDLight)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: the blink phase is derived from elapsed cycles since the
    // counter last restarted, divided by the half-period.
    logic [31:0] m_light, m_blink, m_period, m_led;
    logic        m_en, m_base;
    logic [7:0]  m_duty;
    int unsigned m_elapsed, m_cyc;

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = cur;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    function automatic logic m_phase();
        if (m_period == 0) return m_base;
        return m_base ^ logic'((m_elapsed / m_period) % 2);
    endfunction

    function automatic logic [31:0] exp_dout(input logic [1:0] a);
        logic [7:0] d;
`ifdef LED_PWM_EN
        d = m_duty;
`else
        d = 8'h00;
`endif
        case (a)
            2'd0: return m_light;
            2'd1: return m_blink;
            2'd2: return m_period;
            default: return {15'h0, m_phase(), d, 7'h0, m_en};
        endcase
    endfunction

    task automatic model_reset();
        m_light = 0; m_blink = 0; m_period = 0; m_en = 0; m_duty = 0;
        m_base = 0; m_elapsed = 0; m_cyc = 0; m_led = 32'hFFFF_FFFF;
    endtask

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_edge();
        logic ph, pwm;
        logic [31:0] lit;
        ph = m_phase();
`ifdef LED_PWM_EN
        pwm = (m_duty == 8'hFF) || ((m_cyc % 256) < m_duty);
`else
        pwm = 1'b1;
`endif
        lit   = (m_en && pwm) ? (m_light & (~m_blink | {32{ph}})) : 32'h0;
        m_led = ~lit;
        if (m_period == 0) begin
            m_base = 1'b1; m_elapsed = 0;
        end else if (WE && Addr == 2'd2) begin
            m_base = ph; m_elapsed = 0;
        end else begin
            m_elapsed++;
        end
        if (WE) begin
            case (Addr)
                2'd0: m_light  = merge(m_light, DIn, BE);
                2'd1: m_blink  = merge(m_blink, DIn, BE);
                2'd2: m_period = merge(m_period, DIn, BE) & PMASK;
                default: begin
                    if (BE[0]) m_en = DIn[0];
`ifdef LED_PWM_EN
                    if (BE[1]) m_duty = DIn[15:8];
`endif
                end
            endcase
        end
        m_cyc++;
    endtask

    // One bus cycle: drive at the falling edge, clock, then compare at the next falling edge.
    task automatic step(input logic we, input logic [1:0] a, input logic [3:0] be,
                        input logic [31:0] d);
        WE = we; Addr = a; BE = be; DIn = d;
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        WE = 1'b0;
        check("led", LEDLight, m_led);
        check("dout", DOut, exp_dout(Addr));
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(1'b1, a, 4'hF, d);
    endtask

    task automatic idle(input int n, input logic [1:0] a);
        for (int i = 0; i < n; i++) step(1'b0, a, 4'h0, 32'h0);
    endtask

    initial begin
        model_reset();
        // Reset state: all registers read zero, pins dark.
        repeat (2) @(negedge Clk);
        for (int a = 0; a < 4; a++) begin
            Addr = 2'(a);
            #1 check("rst_dout", DOut, 32'h0);
        end
        check("rst_led", LEDLight, 32'hFFFF_FFFF);
        @(negedge Clk);
        Reset = 1'b1;
        Addr  = 2'd3;
        #1 check("rel_ctrl", DOut, 32'h0);

        // Enable plus static pattern, with one cycle of pin latency.
        wr(2'd3, 32'h0000_0001);
        wr(2'd0, 32'h0000_00A5);
        check("lat_before", LEDLight, 32'hFFFF_FFFF);
        idle(1, 2'd0);
        check("lat_after", LEDLight, 32'hFFFF_FF5A);
        step(1'b1, 2'd0, 4'b0010, 32'hFFFF_FFFF);
        check("light_be", DOut, 32'h0000_FFA5);

        // Only EN reaches CTRL without the PWM stage; PHASE tracks the model.
        wr(2'd3, 32'h0000_4001);
`ifdef LED_PWM_EN
        check("ctrl_rd", DOut, {15'h0, m_phase(), 16'h4001});
`else
        check("ctrl_rd", DOut, {15'h0, m_phase(), 16'h0001});
        check("ctrl_lit", {31'h0, LEDLight[0]}, 32'h0);
`endif
        wr(2'd3, 32'h0000_FF01);

        // Blinking channel 0 with a 4-cycle half-period, then shrink to 2 mid-way.
        wr(2'd0, 32'h0000_0001);
        wr(2'd1, 32'h0000_0001);
        wr(2'd2, 32'h0000_0004);
        idle(10, 2'd3);
        wr(2'd2, 32'h0000_0002);
        idle(8, 2'd3);

        // Zero period: blinking channel steady on, PHASE reads 1.
        wr(2'd2, 32'h0000_0000);
        idle(4, 2'd3);
        check("p0_led", {31'h0, LEDLight[0]}, 32'h0);
        check("p0_phase", {31'h0, DOut[16]}, 32'h1);

`ifdef LED_PWM_EN
        wr(2'd3, 32'h0000_4001);
        idle(300, 2'd3);
        wr(2'd3, 32'h0000_0001);
        idle(20, 2'd3);
        wr(2'd3, 32'h0000_FF01);
        idle(20, 2'd3);
`endif

        // Asynchronous reset between edges during an active blink.
        wr(2'd2, 32'h0000_0003);
        idle(5, 2'd3);
        @(posedge Clk);
        model_edge();
        #2 Reset = 1'b0;
        #1 check("arst_led", LEDLight, 32'hFFFF_FFFF);
        check("arst_dout", DOut, 32'h0);
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        wr(2'd0, 32'h0000_0001);
        wr(2'd1, 32'h0000_0001);
        wr(2'd3, 32'h0000_FF01);
        wr(2'd2, 32'h0000_0003);
        idle(12, 2'd3);

        // Random register traffic checked every cycle against the model.
        for (int n = 0; n < 2500; n++) begin
            logic [1:0]  a;
            logic [31:0] d;
            a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                d = $urandom;
                if (a == 2'd2) d = $urandom_range(0, 6);
                if (a == 2'd3 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
                step(1'b1, a, 4'($urandom_range(0, 15)), d);
            end else begin
                step(1'b0, a, 4'h0, 32'h0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
